// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one aligned bus access per EXU handshake, with lane steering,
// load extension, misalignment detection and a bus-response timeout.
//
// state  | meaning
// S_IDLE | ready for a new access; latch op/addr/wdata on in_valid
// S_REQ  | bus request presented; held until mem_req_ready
// S_WAIT | awaiting read data / write ack; timeout counter running
// S_DONE | result presented to WBU until out_ready
module lsu_mem_ctrl #(
   parameter int XLEN        = 64,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [XLEN-1:0]   in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_data,
   output logic              out_err,
   output logic              out_cause,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic              mem_req_wen,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [XLEN/8-1:0] mem_req_wmask,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_data
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int CW   = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_size;
   logic            r_uns;
   logic            r_wen;
   logic [OFFW-1:0] r_off;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [NB-1:0]   r_wmask;
   logic [XLEN-1:0] r_data;
   logic            r_err;
   logic            r_cause;

   logic [1:0]      w_size;
   logic [OFFW-1:0] w_off;
   logic            w_misal;
   logic [NB-1:0]   w_lanes;
   logic [NB-1:0]   w_wmask;
   logic [XLEN-1:0] w_wdata_sh;
   logic [XLEN-1:0] w_field;
   logic [XLEN-1:0] w_ext;
   logic            w_tmo;

   assign w_size     = in_op[1:0];
   assign w_off      = in_addr[OFFW-1:0];
   assign w_wdata_sh = in_wdata << {w_off, 3'b000};
   assign w_wmask    = w_lanes << w_off;
   assign w_field    = mem_rsp_data >> {r_off, 3'b000};
   assign w_tmo      = (r_cnt == CW'(TIMEOUT_CYC - 1));

   // Doubleword is illegal on a 32-bit bus and reported like a misalignment.
   always_comb begin
      w_misal = 1'b0;
      case (w_size)
         2'd0:    w_misal = 1'b0;
         2'd1:    w_misal = in_addr[0];
         2'd2:    w_misal = |in_addr[1:0];
         default: w_misal = (XLEN == 32) || (|in_addr[2:0]);
      endcase
   end

   always_comb begin
      w_lanes = '0;
      for (int i = 0; i < NB; i++) w_lanes[i] = (i < (1 << w_size));
   end

   always_comb begin
      int nbits;
      nbits = 8 << r_size;
      if (nbits > XLEN) nbits = XLEN;
      w_ext = '0;
      for (int i = 0; i < XLEN; i++) begin
         if (i < nbits) w_ext[i] = w_field[i];
         else           w_ext[i] = ~r_uns & w_field[nbits-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      in_ready      = 1'b0;
      mem_req_valid = 1'b0;
      out_valid     = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = w_misal ? S_DONE : S_REQ;
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rsp_valid || w_tmo) w_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_size  <= '0;
         r_uns   <= 1'b0;
         r_wen   <= 1'b0;
         r_off   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_data  <= '0;
         r_err   <= 1'b0;
         r_cause <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_size  <= w_size;
                  r_uns   <= in_op[2];
                  r_wen   <= in_op[3];
                  r_off   <= w_off;
                  r_addr  <= {in_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                  r_wdata <= in_op[3] ? w_wdata_sh : '0;
                  r_wmask <= in_op[3] ? w_wmask : '0;
                  r_data  <= '0;
                  r_err   <= w_misal;
                  r_cause <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            S_REQ: begin
               if (mem_req_ready) r_cnt <= '0;
            end
            S_WAIT: begin
               // A response in the final timeout cycle still completes normally.
               if (mem_rsp_valid) begin
                  r_data <= r_wen ? '0 : w_ext;
               end else if (w_tmo) begin
                  r_err   <= 1'b1;
                  r_cause <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req_addr  = r_addr;
   assign mem_req_wen   = r_wen;
   assign mem_req_wdata = r_wdata;
   assign mem_req_wmask = r_wmask;
   assign out_data      = r_data;
   assign out_err       = r_err;
   assign out_cause     = r_cause;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl (XLEN=64, TIMEOUT_CYC=4): directed cases plus
// randomized accesses checked against a byte-arithmetic reference model.
module tb_lsu_mem_ctrl;
   localparam int TO = 4;

   typedef struct packed {
      logic [63:0] data;
      logic        err;
      logic        cause;
   } out_t;

   typedef struct packed {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } req_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [63:0] in_addr;
   logic [63:0] in_wdata;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_err;
   logic        out_cause;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_req_wen;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;

   int   n_chk  = 0;
   int   n_pass = 0;
   out_t q_out[$];
   req_t q_req[$];
   out_t m_eo;
   req_t m_er;

   lsu_mem_ctrl #(.XLEN(64), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err(out_err), .out_cause(out_cause),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
      .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk64(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic void chk1(string name, logic act, logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
   endfunction

   // Reference: byte-granular arithmetic on the access size and byte offset.
   function automatic out_t model_out(logic [3:0] op, logic [63:0] addr,
                                      logic [63:0] rsp, int delay);
      out_t        o;
      int          n;
      int          off;
      int          nbits;
      logic [63:0] v;
      logic [63:0] m;
      o     = '0;
      n     = 1 << op[1:0];
      off   = int'(addr[2:0]);
      if ((off % n) != 0) begin
         o.err = 1'b1;
         return o;
      end
      if (delay >= TO) begin
         o.err   = 1'b1;
         o.cause = 1'b1;
         return o;
      end
      if (op[3]) return o;
      nbits = 8 * n;
      v     = rsp >> (8 * off);
      if (nbits < 64) begin
         m = (64'd1 << nbits) - 64'd1;
         v = v & m;
         if (!op[2] && v[nbits-1]) v = v | ~m;
      end
      o.data = v;
      return o;
   endfunction

   function automatic req_t model_req(logic [3:0] op, logic [63:0] addr, logic [63:0] wdata);
      req_t r;
      int   n;
      int   off;
      n       = 1 << op[1:0];
      off     = int'(addr[2:0]);
      r.addr  = addr - 64'(off);
      r.wen   = op[3];
      r.wdata = op[3] ? (wdata << (8 * off)) : 64'd0;
      r.wmask = op[3] ? 8'(((1 << n) - 1) << off) : 8'h00;
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         if (out_valid && out_ready) begin
            if (q_out.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_out: got data %h err %b, expected no result", out_data, out_err);
            end else begin
               m_eo = q_out.pop_front();
               chk64("out_data", out_data, m_eo.data);
               chk1("out_err", out_err, m_eo.err);
               chk1("out_cause", out_cause, m_eo.cause);
            end
         end
         if (mem_req_valid && mem_req_ready) begin
            if (q_req.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_req: got addr %h, expected no request", mem_req_addr);
            end else begin
               m_er = q_req.pop_front();
               chk64("req_addr", mem_req_addr, m_er.addr);
               chk1("req_wen", mem_req_wen, m_er.wen);
               chk64("req_wmask", 64'(mem_req_wmask), 64'(m_er.wmask));
               if (m_er.wen) chk64("req_wdata", mem_req_wdata, m_er.wdata);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_access(input logic [3:0] op, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] rspd,
                            input int req_stall, input int rsp_delay, input int out_stall,
                            input bit late_rsp, input out_t eo, input req_t er);
      int n;
      bit misal;
      misal = eo.err && !eo.cause;
      q_out.push_back(eo);
      if (!misal) q_req.push_back(er);
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      chk1("in_ready_idle", in_ready, 1'b1);
      in_valid = 1'b1;
      in_op    = op;
      in_addr  = addr;
      in_wdata = wdata;
      tick();
      in_valid = 1'b0;
      chk1("in_ready_busy", in_ready, 1'b0);
      if (misal) begin
         chk1("misal_no_req", mem_req_valid, 1'b0);
         chk1("misal_out_valid", out_valid, 1'b1);
      end else begin
         chk1("req_valid", mem_req_valid, 1'b1);
         for (int i = 0; i < req_stall; i++) begin
            tick();
            chk1("req_held", mem_req_valid, 1'b1);
            chk1("req_stall_no_out", out_valid, 1'b0);
         end
         mem_req_ready = 1'b1;
         tick();
         mem_req_ready = 1'b0;
         if (rsp_delay < TO) begin
            for (int i = 0; i < rsp_delay; i++) begin
               chk1("wait_no_out", out_valid, 1'b0);
               tick();
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = rspd;
            tick();
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = {$urandom, $urandom};
         end else begin
            for (int i = 0; i < TO; i++) begin
               chk1("wait_no_out", out_valid, 1'b0);
               tick();
            end
         end
         chk1("out_valid_latency", out_valid, 1'b1);
      end
      if (late_rsp) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = {$urandom, $urandom};
         tick();
         mem_rsp_valid = 1'b0;
         chk1("late_rsp_out_held", out_valid, 1'b1);
      end
      for (int i = 0; i < out_stall; i++) begin
         tick();
         chk1("out_held", out_valid, 1'b1);
         chk1("out_stall_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk1("back_idle_in_ready", in_ready, 1'b1);
      chk1("back_idle_out_valid", out_valid, 1'b0);
   endtask

   task automatic check_idle_zero(string tag);
      chk1({tag, "_in_ready"}, in_ready, 1'b1);
      chk1({tag, "_out_valid"}, out_valid, 1'b0);
      chk1({tag, "_req_valid"}, mem_req_valid, 1'b0);
      chk64({tag, "_out_data"}, out_data, 64'd0);
      chk1({tag, "_out_err"}, out_err, 1'b0);
      chk1({tag, "_out_cause"}, out_cause, 1'b0);
      chk64({tag, "_req_addr"}, mem_req_addr, 64'd0);
      chk1({tag, "_req_wen"}, mem_req_wen, 1'b0);
      chk64({tag, "_req_wdata"}, mem_req_wdata, 64'd0);
      chk64({tag, "_req_wmask"}, 64'(mem_req_wmask), 64'd0);
   endtask

   initial begin
      logic [3:0]  op;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rspd;
      int          dly;
      rst           = 1'b0;
      in_valid      = 1'b0;
      in_op         = 4'd0;
      in_addr       = 64'd0;
      in_wdata      = 64'd0;
      out_ready     = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 64'd0;
      repeat (3) tick();
      check_idle_zero("reset");
      rst = 1'b1;
      tick();

      // lb / lbu on byte 3 of the word
      do_access(4'b0000, 64'h8000_0003, 64'd0, 64'h0000_0000_F000_0000, 0, 0, 0, 1'b0,
                '{64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0},
                '{64'h8000_0000, 1'b0, 64'd0, 8'h00});
      do_access(4'b0100, 64'h8000_0003, 64'd0, 64'h0000_0000_F000_0000, 0, 0, 0, 1'b0,
                '{64'h0000_0000_0000_00F0, 1'b0, 1'b0},
                '{64'h8000_0000, 1'b0, 64'd0, 8'h00});
      // sw to upper word
      do_access(4'b1010, 64'h8000_0004, 64'h1122_3344_5566_7788, 64'hDEAD, 0, 1, 0, 1'b0,
                '{64'd0, 1'b0, 1'b0},
                '{64'h8000_0000, 1'b1, 64'h5566_7788_0000_0000, 8'hF0});
      // misaligned lh
      do_access(4'b0001, 64'h8000_0001, 64'd0, 64'd0, 0, 0, 0, 1'b0,
                '{64'd0, 1'b1, 1'b0},
                '{64'd0, 1'b0, 64'd0, 8'h00});
      // timeout, then a late response while the error is held
      do_access(4'b0010, 64'h8000_0008, 64'd0, 64'd0, 0, TO, 1, 1'b1,
                '{64'd0, 1'b1, 1'b1},
                '{64'h8000_0008, 1'b0, 64'd0, 8'h00});
      do_access(4'b0110, 64'h8000_000C, 64'd0, 64'h8765_4321_0000_0000, 0, 0, 0, 1'b0,
                '{64'h0000_0000_8765_4321, 1'b0, 1'b0},
                '{64'h8000_0008, 1'b0, 64'd0, 8'h00});
      do_access(4'b0010, 64'h8000_000C, 64'd0, 64'h8765_4321_0000_0000, 0, 0, 0, 1'b0,
                '{64'hFFFF_FFFF_8765_4321, 1'b0, 1'b0},
                '{64'h8000_0008, 1'b0, 64'd0, 8'h00});
      // ld with bus back-pressure and WBU back-pressure
      do_access(4'b0011, 64'h8000_0010, 64'd0, 64'hDEAD_BEEF_0123_4567, 3, 0, 5, 1'b0,
                '{64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0},
                '{64'h8000_0010, 1'b0, 64'd0, 8'h00});
      // response on the last timeout cycle completes normally
      do_access(4'b0101, 64'h8000_0006, 64'd0, 64'hABCD_0000_0000_0000, 0, TO - 1, 0, 1'b0,
                '{64'h0000_0000_0000_ABCD, 1'b0, 1'b0},
                '{64'h8000_0000, 1'b0, 64'd0, 8'h00});

      // reset during WAIT abandons the access
      q_req.push_back('{64'h8000_0020, 1'b0, 64'd0, 8'h00});
      in_valid = 1'b1;
      in_op    = 4'b0011;
      in_addr  = 64'h8000_0020;
      tick();
      in_valid      = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check_idle_zero("midreset");
      rst           = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h1234_5678_9ABC_DEF0;
      tick();
      mem_rsp_valid = 1'b0;
      tick();
      chk1("post_reset_rsp_in_ready", in_ready, 1'b1);
      chk1("post_reset_rsp_out_valid", out_valid, 1'b0);
      chk64("post_reset_rsp_out_data", out_data, 64'd0);

      for (int t = 0; t < 200; t++) begin
         op    = 4'($urandom_range(0, 15));
         addr  = {$urandom, $urandom};
         if ($urandom_range(0, 9) < 7) addr = addr & ~((64'd1 << op[1:0]) - 64'd1);
         wdata = {$urandom, $urandom};
         rspd  = {$urandom, $urandom};
         dly   = $urandom_range(0, 5);
         do_access(op, addr, wdata, rspd, $urandom_range(0, 3), dly, $urandom_range(0, 3),
                   (dly >= TO) && ($urandom_range(0, 1) == 1),
                   model_out(op, addr, rspd, dly), model_req(op, addr, wdata));
      end

      tick();
      chk64("out_queue_drained", 64'(q_out.size()), 64'd0);
      chk64("req_queue_drained", 64'(q_req.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
